// File: rtl/aes_key_seq_if.sv
// Register-bus write port from the key sequencer (master) to the AES0 key registers (slave).
interface aes_key_seq_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [63:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_gnt_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_gnt_i
    );
endinterface

// File: rtl/aes_key_seq.sv
// AES0 key-load sequencer: copies a 128-bit fuse key into an AES0 key slot, word by word.
// Optional zeroize path (clear_i) is built only when AES_KEYSEQ_ZEROIZE_EN is defined.
module aes_key_seq #(
    parameter logic [63:0] AES_BASE       = 64'hfff5200000,
    parameter logic [63:0] WORD_STRIDE    = 64'd8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [1:0]    key_id_i,
    input  logic [2:0]    reglk_i,
`ifdef AES_KEYSEQ_ZEROIZE_EN
    input  logic          clear_i,
`endif
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [1:0]    err_code_o,
    output logic          fuse_req_o,
    output logic [3:0]    fuse_addr_o,
    input  logic [31:0]   fuse_rdata_i,
    aes_key_seq_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_ID  = 2'd1;
    localparam logic [1:0] ERR_LOCKED  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FUSE_RD,
        S_FUSE_WAIT,
        S_BUS_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [1:0]    r_keyId;
    logic [1:0]    r_word;
    logic [31:0]   r_wdata;
    logic [1:0]    r_errCode;
    logic [TW-1:0] r_tmo;

    logic          w_accept;
    logic          w_clear;
    logic          w_zero;
    logic          w_locked;
    logic          w_setErr;
    logic [1:0]    w_errCode;
    logic [63:0]   w_slotBase;
    logic [63:0]   w_busAddr;

`ifdef AES_KEYSEQ_ZEROIZE_EN
    logic          r_zero;

    assign w_clear = clear_i;
    assign w_zero  = r_zero;
`else
    assign w_clear = 1'b0;
    assign w_zero  = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && (start_i || w_clear);

    always_comb begin
        w_locked   = 1'b0;
        w_slotBase = AES_BASE;
        case (r_keyId)
            2'd0: begin
                w_locked   = reglk_i[0];
                w_slotBase = AES_BASE + 64'd40;
            end
            2'd1: begin
                w_locked   = reglk_i[1];
                w_slotBase = AES_BASE + 64'd112;
            end
            2'd2: begin
                w_locked   = reglk_i[2];
                w_slotBase = AES_BASE + 64'd144;
            end
            default: begin
                w_locked   = 1'b0;
                w_slotBase = AES_BASE;
            end
        endcase
    end

    assign w_busAddr = w_slotBase + WORD_STRIDE * {62'd0, r_word};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_setErr  = 1'b0;
        w_errCode = ERR_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_keyId == 2'd3) begin
                    w_next    = S_ERR;
                    w_setErr  = 1'b1;
                    w_errCode = ERR_BAD_ID;
                end else if (w_locked) begin
                    w_next    = S_ERR;
                    w_setErr  = 1'b1;
                    w_errCode = ERR_LOCKED;
                end else if (w_zero) begin
                    w_next = S_BUS_WR;
                end else begin
                    w_next = S_FUSE_RD;
                end
            end
            S_FUSE_RD: begin
                w_next = S_FUSE_WAIT;
            end
            S_FUSE_WAIT: begin
                w_next = S_BUS_WR;
            end
            S_BUS_WR: begin
                // A grant in the final timeout cycle still completes the write.
                if (bus.bus_gnt_i) begin
                    if (r_word == 2'd3) begin
                        w_next = S_DONE;
                    end else if (w_zero) begin
                        w_next = S_BUS_WR;
                    end else begin
                        w_next = S_FUSE_RD;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_next    = S_ERR;
                    w_setErr  = 1'b1;
                    w_errCode = ERR_TIMEOUT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o          = (r_state != S_IDLE);
        done_o          = (r_state == S_DONE);
        err_o           = (r_state == S_ERR);
        err_code_o      = r_errCode;
        fuse_req_o      = (r_state == S_FUSE_RD);
        fuse_addr_o     = 4'd0;
        bus.bus_req_o   = (r_state == S_BUS_WR);
        bus.bus_we_o    = (r_state == S_BUS_WR);
        bus.bus_addr_o  = 64'd0;
        bus.bus_wdata_o = 32'd0;
        if (r_state == S_FUSE_RD) begin
            fuse_addr_o = {r_keyId, r_word};
        end
        if (r_state == S_BUS_WR) begin
            bus.bus_addr_o  = w_busAddr;
            bus.bus_wdata_o = r_wdata;
        end
    end

    // The word counter wraps 3 -> 0 naturally on the final grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_keyId   <= 2'd0;
            r_word    <= 2'd0;
            r_wdata   <= 32'd0;
            r_errCode <= ERR_NONE;
            r_tmo     <= '0;
        end else begin
            if (w_accept) begin
                r_keyId   <= key_id_i;
                r_word    <= 2'd0;
                r_wdata   <= 32'd0;
                r_errCode <= ERR_NONE;
            end
            if (w_setErr) begin
                r_errCode <= w_errCode;
            end
            if (r_state == S_FUSE_WAIT) begin
                r_wdata <= fuse_rdata_i;
            end
            if ((r_state == S_BUS_WR) && bus.bus_gnt_i) begin
                r_word <= r_word + 2'd1;
            end
            if ((r_state == S_BUS_WR) && !bus.bus_gnt_i) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
        end
    end

`ifdef AES_KEYSEQ_ZEROIZE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zero <= w_clear;
        end
    end
`endif

`ifndef SYNTHESIS
    a_doneErrExclusive: assert property (@(posedge clk_i) disable iff (rst_i) !(done_o && err_o));
    a_weFollowsReq:     assert property (@(posedge clk_i) disable iff (rst_i) bus.bus_we_o == bus.bus_req_o);
`endif

endmodule

// File: tb/tb_aes_key_seq.sv
// Scoreboard testbench for aes_key_seq: random and directed key loads against a spec-level model.
module tb_aes_key_seq;

    localparam logic [63:0] AES_BASE = 64'hfff5200000;
    localparam int TMO = 8;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } write_t;

    typedef struct packed {
        logic       isErr;
        logic [1:0] code;
    } comp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  keyId = 2'd0;
    logic [2:0]  reglk = 3'd0;
`ifdef AES_KEYSEQ_ZEROIZE_EN
    logic        clear = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  errCode;
    logic        fuseReq;
    logic [3:0]  fuseAddr;
    logic [31:0] fuseRdata = 32'd0;

    aes_key_seq_if busIf ();

    aes_key_seq #(
        .AES_BASE       (AES_BASE),
        .WORD_STRIDE    (64'd8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .key_id_i     (keyId),
        .reglk_i      (reglk),
`ifdef AES_KEYSEQ_ZEROIZE_EN
        .clear_i      (clear),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_code_o   (errCode),
        .fuse_req_o   (fuseReq),
        .fuse_addr_o  (fuseAddr),
        .fuse_rdata_i (fuseRdata),
        .bus          (busIf.master)
    );

    always #5 clk = ~clk;

    write_t      writeQ[$];
    logic [3:0]  fuseQ[$];
    comp_t       compQ[$];
    logic [31:0] fuseMem [16];

    int total = 0;
    int bad = 0;

    int   gntDelay = 0;
    bit   gntNever = 1'b0;
    int   waitCnt = 0;
    logic prevReq = 1'b0;
    logic [3:0] prevAddr = 4'd0;
    bit   holdValid = 1'b0;
    logic [63:0] holdAddr = 64'd0;
    logic [31:0] holdData = 32'd0;

    initial busIf.bus_gnt_i = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportMissing(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: DUT output with nothing expected, got 1 expected 0 (t=%0t)", name, $time);
    endtask

    function automatic logic [63:0] slotBase(input logic [1:0] id);
        case (id)
            2'd0:    return AES_BASE + 64'h28;
            2'd1:    return AES_BASE + 64'h70;
            default: return AES_BASE + 64'h90;
        endcase
    endfunction

    // Bus slave, fuse store and monitor, all sampled mid-cycle.
    always @(negedge clk) begin
        fuseRdata = prevReq ? fuseMem[prevAddr] : $urandom();
        prevReq   = fuseReq;
        prevAddr  = fuseAddr;

        if (busIf.bus_req_o && !gntNever && !rst) begin
            if (waitCnt >= gntDelay) begin
                busIf.bus_gnt_i = 1'b1;
                waitCnt = 0;
            end else begin
                busIf.bus_gnt_i = 1'b0;
                waitCnt++;
            end
        end else begin
            busIf.bus_gnt_i = 1'b0;
            waitCnt = 0;
        end

        if (rst) begin
            holdValid = 1'b0;
        end else begin
            if (fuseReq) begin
                if (fuseQ.size() == 0) reportMissing("fuse_req");
                else checkOutput("fuse_addr", 64'(fuseAddr), 64'(fuseQ.pop_front()));
            end
            if (busIf.bus_req_o) begin
                checkOutput("bus_we", 64'(busIf.bus_we_o), 64'd1);
                if (holdValid) begin
                    checkOutput("addr_stable", busIf.bus_addr_o, holdAddr);
                    checkOutput("wdata_stable", 64'(busIf.bus_wdata_o), 64'(holdData));
                end
                if (busIf.bus_gnt_i) begin
                    if (writeQ.size() == 0) begin
                        reportMissing("bus_write");
                    end else begin
                        write_t w;
                        w = writeQ.pop_front();
                        checkOutput("write_addr", busIf.bus_addr_o, w.addr);
                        checkOutput("write_data", 64'(busIf.bus_wdata_o), 64'(w.data));
                    end
                    holdValid = 1'b0;
                end else begin
                    holdValid = 1'b1;
                    holdAddr  = busIf.bus_addr_o;
                    holdData  = busIf.bus_wdata_o;
                end
            end else begin
                holdValid = 1'b0;
            end
            if (done || err) begin
                checkOutput("done_err_exclusive", 64'(done && err), 64'd0);
                if (compQ.size() == 0) begin
                    reportMissing("completion");
                end else begin
                    comp_t c;
                    c = compQ.pop_front();
                    checkOutput("completion", 64'({err, errCode}), 64'({c.isErr, c.code}));
                end
            end
        end
    end

    // mode: 0 start, 1 clear, 2 start+clear (clear wins); never: grant withheld forever.
    task automatic applyStimulus(input int mode, input logic [1:0] id, input logic [2:0] lk,
                                 input int dly, input bit never);
        int lat;
        int expLat;
        logic [1:0] expCode;
        bit zero;
        zero = (mode != 0);
        @(negedge clk);
        gntDelay = dly;
        gntNever = never;
        keyId    = id;
        reglk    = lk;
        if (id == 2'd3) begin
            expCode = 2'd1;
            expLat  = 2;
        end else if (((lk >> id) & 3'b001) != 3'b000) begin
            expCode = 2'd2;
            expLat  = 2;
        end else if (never) begin
            if (!zero) fuseQ.push_back({id, 2'd0});
            expCode = 2'd3;
            expLat  = zero ? (1 + TMO + 1) : (3 + TMO + 1);
        end else begin
            for (int w = 0; w < 4; w++) begin
                write_t e;
                if (!zero) fuseQ.push_back({id, 2'(w)});
                e.addr = slotBase(id) + 64'(8 * w);
                e.data = zero ? 32'd0 : fuseMem[{id, 2'(w)}];
                writeQ.push_back(e);
            end
            expCode = 2'd0;
            expLat  = 2 + 4 * ((zero ? 1 : 3) + dly);
        end
        compQ.push_back('{isErr: (expCode != 2'd0), code: expCode});

`ifdef AES_KEYSEQ_ZEROIZE_EN
        start = (mode != 1);
        clear = (mode != 0);
`else
        start = 1'b1;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef AES_KEYSEQ_ZEROIZE_EN
        clear = 1'b0;
`endif
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("err_code_cleared", 64'(errCode), 64'd0);
        lat = 1;
        while (!(done || err) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) begin
            reportMissing("completion_timeout");
        end else begin
            checkOutput("latency", 64'(lat), 64'(expLat));
            if (err) checkOutput("req_low_at_err", 64'(busIf.bus_req_o), 64'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("idle_after", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("err_code_held", 64'(errCode), 64'(expCode));
    endtask

    task automatic resetDuringWord2();
        int n;
        @(negedge clk);
        gntDelay = 1;
        gntNever = 1'b0;
        keyId    = 2'd2;
        reglk    = 3'd0;
        for (int w = 0; w < 4; w++) begin
            write_t e;
            fuseQ.push_back({2'd2, 2'(w)});
            e.addr = slotBase(2'd2) + 64'(8 * w);
            e.data = fuseMem[{2'd2, 2'(w)}];
            writeQ.push_back(e);
        end
        compQ.push_back('{isErr: 1'b0, code: 2'd0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(fuseReq && fuseAddr == 4'b1010) && n < 100) begin
            @(negedge clk);
            n++;
        end
        gntNever = 1'b1;
        while (!busIf.bus_req_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) reportMissing("word2_reach_timeout");
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done_err", 64'({done, err}), 64'd0);
        checkOutput("rst_err_code", 64'(errCode), 64'd0);
        checkOutput("rst_bus_req", 64'(busIf.bus_req_o), 64'd0);
        checkOutput("rst_bus_addr", busIf.bus_addr_o, 64'd0);
        checkOutput("rst_fuse_req", 64'(fuseReq), 64'd0);
        checkOutput("pending_writes", 64'(writeQ.size()), 64'd2);
        checkOutput("pending_fuse", 64'(fuseQ.size()), 64'd1);
        writeQ.delete();
        fuseQ.delete();
        compQ.delete();
        @(negedge clk);
        rst = 1'b0;
        gntNever = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, got 1 expected 0");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) fuseMem[i] = $urandom();
        for (int i = 0; i < 4; i++) fuseMem[4 + i] = 32'h000000A0 + 32'(i);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", 64'({busy, done, err, errCode, fuseReq, busIf.bus_req_o}), 64'd0);
        checkOutput("reset_bus_addr", busIf.bus_addr_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 2'd1, 3'b000, 0, 1'b0);
        applyStimulus(0, 2'd3, 3'b000, 0, 1'b0);
        applyStimulus(0, 2'd0, 3'b001, 0, 1'b0);
        applyStimulus(0, 2'd0, 3'b010, 0, 1'b0);
        applyStimulus(0, 2'd2, 3'b000, 3, 1'b0);
        applyStimulus(0, 2'd1, 3'b000, 0, 1'b1);
        resetDuringWord2();
        applyStimulus(0, 2'd2, 3'b000, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [1:0] id;
            logic [2:0] lk;
            int mode;
            id   = 2'($urandom_range(0, 3));
            lk   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
`ifdef AES_KEYSEQ_ZEROIZE_EN
            mode = $urandom_range(0, 2);
`else
            mode = 0;
`endif
            applyStimulus(mode, id, lk, $urandom_range(0, 3), 1'b0);
        end

`ifdef AES_KEYSEQ_ZEROIZE_EN
        applyStimulus(1, 2'd2, 3'b000, 0, 1'b0);
        applyStimulus(2, 2'd0, 3'b000, 2, 1'b0);
        applyStimulus(1, 2'd1, 3'b010, 0, 1'b0);
        applyStimulus(1, 2'd0, 3'b000, 0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("queues_drained", 64'(writeQ.size() + fuseQ.size() + compQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
